// File: rtl/ica_iter_controller.sv
// rtl/ica_iter_controller.sv - ICA fixed-point iteration sequencer
// Launches the fast controller, normalises, checks |w_new.w_old| for convergence.
module ica_iter_controller #(
  parameter logic [7:0]  MAX_ITER = 8'd50,
  parameter int          DW       = 16,
  parameter logic [15:0] TOL      = 16'd16,
  parameter logic [8:0]  WDOG     = 9'd400
) (
  input  logic                 clk_fast,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 fast_busy,
  output logic                 go_fast,
  output logic                 en_norm,
  input  logic                 norm_done,
  input  logic signed [DW-1:0] dot_in,
  input  logic                 dot_valid,
  output logic                 w_load,
  output logic                 busy,
  output logic                 converged,
  output logic                 fail,
  output logic [7:0]           iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_NORM, S_CHECK, S_DONE, S_FAIL
  } state_t;

  // Unity in Q2.14 is 16384; threshold kept DW+1 wide to match |dot_in|.
  localparam logic [DW:0] W_THRESH = (DW+1)'(16384 - int'(TOL));

  state_t      r_state, w_next;
  logic        r_seen_busy;
  logic [8:0]  r_wdog;
  logic [7:0]  r_iter;
  logic        r_conv, r_fail;

  logic [DW:0] w_dot_ext, w_abs;
  logic        w_conv_hit;
  logic [8:0]  w_iter_p1;
  logic        w_clear, w_iter_inc, w_max_fail, w_set_conv, w_set_fail;

  assign w_dot_ext  = {dot_in[DW-1], dot_in};
  assign w_abs      = dot_in[DW-1] ? (~w_dot_ext + 1'b1) : w_dot_ext;
  assign w_conv_hit = (w_abs >= W_THRESH);
  assign w_iter_p1  = {1'b0, r_iter} + 9'd1;

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    go_fast    = 1'b0;
    en_norm    = 1'b0;
    busy       = 1'b0;
    w_load     = 1'b0;
    w_clear    = 1'b0;
    w_iter_inc = 1'b0;
    w_max_fail = 1'b0;
    w_set_conv = 1'b0;
    w_set_fail = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          w_next  = S_LAUNCH;
          w_clear = 1'b1;
        end
      end
      S_LAUNCH: begin
        busy   = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        go_fast = 1'b1;
        busy    = 1'b1;
        // A low fast_busy before the fast controller ever went busy is stale.
        if (!fast_busy && r_seen_busy) begin
          w_next = S_NORM;
        end else if (r_wdog == WDOG - 9'd1) begin
          w_next     = S_FAIL;
          w_set_fail = 1'b1;
        end
      end
      S_NORM: begin
        go_fast = 1'b1;
        busy    = 1'b1;
        en_norm = 1'b1;
        if (norm_done) w_next = S_CHECK;
      end
      S_CHECK: begin
        go_fast = 1'b1;
        busy    = 1'b1;
        if (dot_valid) begin
          if (w_conv_hit) begin
            w_next     = S_DONE;
            w_set_conv = 1'b1;
          end else if (w_iter_p1 == {1'b0, MAX_ITER}) begin
            w_next     = S_FAIL;
            w_set_fail = 1'b1;
            w_max_fail = 1'b1;
          end else begin
            w_next     = S_LAUNCH;
            w_iter_inc = 1'b1;
            w_load     = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      r_seen_busy <= 1'b0;
      r_wdog      <= 9'd0;
      r_iter      <= 8'd0;
      r_conv      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_seen_busy <= 1'b0;
        r_wdog      <= 9'd0;
      end else if (r_state == S_RUN) begin
        if (fast_busy) r_seen_busy <= 1'b1;
        r_wdog <= r_wdog + 9'd1;
      end
      if (w_clear) begin
        r_iter <= 8'd0;
        r_conv <= 1'b0;
        r_fail <= 1'b0;
      end else begin
        if (w_max_fail) r_iter <= MAX_ITER;
        else if (w_iter_inc) r_iter <= w_iter_p1[7:0];
        if (w_set_conv) r_conv <= 1'b1;
        if (w_set_fail) r_fail <= 1'b1;
      end
    end
  end

  assign converged = r_conv;
  assign fail      = r_fail;
  assign iter_cnt  = r_iter;

endmodule

// File: tb/tb_ica_iter_controller.sv
// tb/tb_ica_iter_controller.sv - directed bench for ica_iter_controller
module tb_ica_iter_controller;

  logic               clk_fast = 1'b0;
  logic               rst;
  logic               start, fast_busy, norm_done, dot_valid;
  logic signed [15:0] dot_in;
  logic               go_fast, en_norm, w_load, busy, converged, fail;
  logic [7:0]         iter_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int wl_cnt = 0;

  ica_iter_controller #(.MAX_ITER(8'd3)) dut (
    .clk_fast (clk_fast),
    .rst      (rst),
    .start    (start),
    .fast_busy(fast_busy),
    .go_fast  (go_fast),
    .en_norm  (en_norm),
    .norm_done(norm_done),
    .dot_in   (dot_in),
    .dot_valid(dot_valid),
    .w_load   (w_load),
    .busy     (busy),
    .converged(converged),
    .fail     (fail),
    .iter_cnt (iter_cnt)
  );

  always #5 clk_fast = ~clk_fast;

  always @(negedge clk_fast) if (w_load) wl_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  // Entered with the DUT in LAUNCH; leaves it one cycle after CHECK saw dot_valid.
  task automatic do_pass(input int stale, input int nbusy, input int ndly,
                         input logic signed [15:0] d, input logic exp_wl);
    tick();
    chk("run_go_fast", go_fast, 1);
    fast_busy = 1'b0;
    for (int i = 0; i < stale; i++) begin
      tick();
      chk("stale_no_norm", en_norm, 0);
    end
    fast_busy = 1'b1;
    repeat (nbusy) tick();
    chk("run_before_fall", en_norm, 0);
    fast_busy = 1'b0;
    tick();
    chk("norm_entered", en_norm, 1);
    repeat (ndly) tick();
    norm_done = 1'b1;
    tick();
    norm_done = 1'b0;
    chk("check_en_norm_off", en_norm, 0);
    chk("check_go_fast", go_fast, 1);
    dot_in    = d;
    dot_valid = 1'b1;
    #1;
    chk("w_load", w_load, exp_wl);
    tick();
    dot_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("launch_busy", busy, 1);
    chk("launch_go_fast", go_fast, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fast_busy = 1'b0; norm_done = 1'b0;
    dot_valid = 1'b0; dot_in = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_go_fast", go_fast, 0);
    chk("rst_en_norm", en_norm, 0);
    chk("rst_w_load", w_load, 0);
    chk("rst_conv", converged, 0);
    chk("rst_fail", fail, 0);
    chk("rst_iter", iter_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // First-pass convergence
    do_start();
    do_pass(0, 134, 3, 16'sd16380, 1'b0);
    chk("t1_conv", converged, 1);
    chk("t1_iter", iter_cnt, 0);
    chk("t1_busy", busy, 0);
    chk("t1_go_fast", go_fast, 0);
    chk("t1_wl_cnt", wl_cnt, 0);
    tick();
    chk("t1_conv_hold", converged, 1);

    // Negative dot product converges; start clears the sticky flag
    do_start();
    chk("t2_conv_clr", converged, 0);
    do_pass(0, 10, 1, -16'sd16370, 1'b0);
    chk("t2_conv", converged, 1);

    // MAX_ITER exhaustion with MAX_ITER=3
    wl_cnt = 0;
    do_start();
    do_pass(0, 5, 0, 16'sd8000, 1'b1);
    chk("t3_iter1", iter_cnt, 1);
    chk("t3_relaunch", busy, 1);
    do_pass(0, 5, 0, 16'sd8000, 1'b1);
    chk("t3_iter2", iter_cnt, 2);
    do_pass(0, 5, 0, 16'sd8000, 1'b0);
    chk("t3_fail", fail, 1);
    chk("t3_iter3", iter_cnt, 3);
    chk("t3_go_fast", go_fast, 0);
    chk("t3_conv", converged, 0);
    chk("t3_wl_cnt", wl_cnt, 2);

    // Stale low busy at start of RUN is ignored
    do_start();
    chk("t4_fail_clr", fail, 0);
    chk("t4_iter_clr", iter_cnt, 0);
    do_pass(2, 134, 0, 16'sd16380, 1'b0);
    chk("t4_conv", converged, 1);

    // Watchdog: fast_busy stuck high
    do_start();
    tick();
    fast_busy = 1'b1;
    repeat (399) tick();
    chk("t5_still_run", busy, 1);
    chk("t5_no_fail_yet", fail, 0);
    tick();
    chk("t5_fail", fail, 1);
    chk("t5_busy", busy, 0);
    chk("t5_iter", iter_cnt, 0);
    fast_busy = 1'b0;

    // Ignored start in RUN, ignored dot_valid in NORM, reset in NORM
    wl_cnt = 0;
    do_start();
    tick();
    fast_busy = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_run_busy", busy, 1);
    chk("t6_run_go", go_fast, 1);
    chk("t6_run_no_norm", en_norm, 0);
    repeat (3) tick();
    fast_busy = 1'b0;
    tick();
    chk("t6_norm", en_norm, 1);
    dot_in = 16'sd16380;
    dot_valid = 1'b1;
    tick();
    dot_valid = 1'b0;
    chk("t6_norm_hold", en_norm, 1);
    chk("t6_no_conv", converged, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_go", go_fast, 0);
    chk("t6_rst_en_norm", en_norm, 0);
    chk("t6_rst_fail", fail, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle_hold", busy, 0);
    chk("t6_wl_cnt", wl_cnt, 0);
    do_start();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
